// File: rtl/adder_reg_recover.sv
// ============================================================================
//  Module   : adder_reg_recover
//  Purpose  : Recovers y = {carry,sum} - x - carry_in through a two-stage
//             valid/ready pipeline. Flags out-of-range results and keeps a
//             saturating count of the flagged results that are delivered.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_reg_recover #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 carry_output_bit,
  input  logic [WIDTH-1:0]     sum,
  input  logic [WIDTH-1:0]     x,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 r_s1_valid;
  logic                 r_s1_cout;
  logic [WIDTH-1:0]     r_s1_sum;
  logic [WIDTH-1:0]     r_s1_x;
  logic                 r_s1_cin;
  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_y;
  logic                 r_range_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_advance1;
  logic                 w_advance2;
  logic [WIDTH+1:0]     w_diff;

  // in_ready is combinational through out_ready so a full pipe can accept
  // and emit in the same cycle.
  always_comb begin
    w_advance2 = !r_s2_valid || out_ready;
    w_advance1 = !r_s1_valid || w_advance2;
  end

  // Bit WIDTH+1 marks a negative result, bit WIDTH a result above the range.
  always_comb begin
    w_diff = {1'b0, r_s1_cout, r_s1_sum} - {2'b00, r_s1_x}
             - (WIDTH+2)'(r_s1_cin);
  end

  always_ff @(posedge clk) begin
    if (w_advance1 && in_valid) begin
      r_s1_cout <= carry_output_bit;
      r_s1_sum  <= sum;
      r_s1_x    <= x;
      r_s1_cin  <= carry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_y         <= '0;
      r_range_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_advance1) begin
        r_s1_valid <= in_valid;
      end
      if (w_advance2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_y         <= w_diff[WIDTH-1:0];
          r_range_err <= w_diff[WIDTH+1] | w_diff[WIDTH];
        end
      end
      if (r_s2_valid && out_ready && r_range_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_advance1;
  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign range_err = r_range_err;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_reg_recover.sv
// ============================================================================
//  Module   : tb_adder_reg_recover
//  Purpose  : Self-checking bench for adder_reg_recover with a queue-based
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_reg_recover;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       carry_output_bit;
  logic [7:0] sum;
  logic [7:0] x;
  logic       carry_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       range_err;
  logic [7:0] err_count;

  adder_reg_recover #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .carry_output_bit (carry_output_bit),
    .sum              (sum),
    .x                (x),
    .carry_in         (carry_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .y                (y),
    .range_err        (range_err),
    .err_count        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: transactions in flight, tagged with the edge that accepted them.
  typedef struct {
    logic [7:0] y;
    logic       err;
    int         acc;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ent_t model(input logic c, input logic [7:0] s,
                                 input logic [7:0] xx, input logic ci, input int acc);
    ent_t e;
    int   v;
    v     = int'(c) * 256 + int'(s) - int'(xx) - int'(ci);
    e.err = (v < 0) || (v > 255);
    e.y   = 8'((v + 512) % 256);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    logic exp_ov;
    if (reset) begin
      q.delete();
      model_cnt = 0;
    end else begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      exp_ov = (q.size() >= 2) || (q.size() == 1 && cyc >= q[0].acc + 1);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("y", y, q[0].y);
        chk("range_err", range_err, q[0].err);
      end
      chk("err_count", err_count, model_cnt);
      if (exp_ov && out_ready) begin
        if (q[0].err && model_cnt < 255) model_cnt++;
        void'(q.pop_front());
      end
      if (in_valid && in_ready)
        q.push_back(model(carry_output_bit, sum, x, carry_in, cyc + 1));
    end
  end

  task automatic send(input logic c, input logic [7:0] s, input logic [7:0] xx, input logic ci);
    bit acc = 0;
    in_valid = 1'b1; carry_output_bit = c; sum = s; x = xx; carry_in = ci;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ye, input logic ee);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, waited, 1);
    chk({tag, "_y"}, y, ye);
    chk({tag, "_err"}, range_err, ee);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] bp_tx [4];
    int         ptr;
    int         cnt0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    carry_output_bit = 1'b0; sum = '0; x = '0; carry_in = 1'b0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 0);
    @(posedge clk); #1;

    // Directed arithmetic cases
    send(1'b0, 8'h47, 8'h12, 1'b1); expect_out("roundtrip", 8'h34, 1'b0); idle(2);
    send(1'b1, 8'hFF, 8'hFF, 1'b1); expect_out("carry_a", 8'hFF, 1'b0); idle(2);
    send(1'b1, 8'h00, 8'h01, 1'b0); expect_out("carry_b", 8'hFF, 1'b0); idle(2);
    cnt0 = int'(err_count);
    send(1'b0, 8'h05, 8'h10, 1'b0); expect_out("neg", 8'hF5, 1'b1); idle(2);
    send(1'b1, 8'h80, 8'h00, 1'b0); expect_out("over", 8'h80, 1'b1); idle(2);
    chk("errcnt_two", err_count, cnt0 + 2);

    // Back-pressure: four transactions against a stalled output
    for (int i = 0; i < 4; i++) bp_tx[i] = 9'($urandom);
    out_ready = 1'b0; ptr = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; carry_output_bit = 1'b0; sum = bp_tx[ptr][7:0]; x = 8'h03; carry_in = bp_tx[ptr][8];
      @(negedge clk);
      if (in_ready) ptr++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", ptr, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    while (ptr < 4) begin
      in_valid = 1'b1; carry_output_bit = 1'b0; sum = bp_tx[ptr][7:0]; x = 8'h03; carry_in = bp_tx[ptr][8];
      @(negedge clk);
      if (in_ready) ptr++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(4);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 2000; i++) begin
      in_valid         = ($urandom % 4) != 0;
      out_ready        = ($urandom % 4) != 0;
      carry_output_bit = 1'($urandom);
      sum              = 8'($urandom);
      x                = 8'($urandom);
      carry_in         = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(4);

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) send(1'b0, 8'h00, 8'h01, 1'b0);
    idle(4);
    chk("sat_err_count", err_count, 8'hFF);
    send(1'b0, 8'h00, 8'h02, 1'b0);
    idle(4);
    chk("sat_hold", err_count, 8'hFF);

    // Reset with both stages full
    out_ready = 1'b0;
    send(1'b0, 8'h10, 8'h01, 1'b0);
    send(1'b0, 8'h20, 8'h01, 1'b0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(6);
    chk("midrst_no_stale", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
